// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared FSM state encoding and reset pattern for the serial pattern detector.
package seq_ctrl_pkg;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
    localparam logic [3:0] PAT_DEFAULT = 4'b0101;
endpackage

// File: rtl/sd_shift_matcher.sv
// sd_shift_matcher: bit history, saturating seen counter, length-masked compare and registered match pulse.
module sd_shift_matcher #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic             clr_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             match_o
);
    logic [PAT_W-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0] seen_q, seen_d;
    logic             match_q, hit;

    always_comb begin
        hist_d = (hist_q << 1) | PAT_W'(bit_i);
        seen_d = (seen_q == LEN_W'(PAT_W)) ? seen_q : seen_q + 1'b1;
        mask   = ~({PAT_W{1'b1}} << len_i);
        hit    = (seen_d >= len_i) && (((hist_d ^ pat_i) & mask) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else if (clr_i) begin
            hist_q  <= '0;
            seen_q  <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= shift_i & hit;
            if (shift_i) begin
                hist_q <= hist_d;
                seen_q <= seen_d;
            end
        end
    end

    assign match_o = match_q;
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: word handshake, MSB-first serializer, pattern config and saturating match counter with sticky irq.
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [2:0]        cfg_len,
    input  logic [CNT_W-1:0]  cfg_thr,
    input  logic              cnt_clr,
    input  logic              flush,
    output logic              busy,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e             state_q;
    logic [DATA_W-1:0]  shreg_q;
    logic [IDX_W-1:0]   idx_q;
    logic [PAT_W-1:0]   pat_q;
    logic [2:0]         len_q, len_cl;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d, ready_q, busy_q;
    logic               xfer, cfg_ok;

    always_comb begin
        xfer   = in_valid & ready_q & ~flush;
        cfg_ok = cfg_we & (state_q == ST_IDLE) & ~xfer;
        len_cl = (cfg_len == 3'd0 || cfg_len > 3'(PAT_W)) ? 3'(PAT_W) : cfg_len;
        cnt_d  = cnt_clr ? '0 : (match && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        irq_d  = !cnt_clr && (irq_q || (cfg_thr != '0 && cnt_d >= cfg_thr));
    end

    // in_ready/busy are registered alongside the state so they never depend on same-cycle inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            pat_q   <= PAT_W'(PAT_DEFAULT);
            len_q   <= 3'(PAT_W);
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (flush) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end else if (xfer) begin
                shreg_q <= in_data;
                idx_q   <= IDX_W'(DATA_W - 1);
                state_q <= ST_SHIFT;
                ready_q <= (DATA_W == 1);
                busy_q  <= 1'b1;
            end else if (state_q == ST_SHIFT) begin
                idx_q   <= idx_q - 1'b1;
                state_q <= (idx_q == '0) ? ST_IDLE : ST_SHIFT;
                ready_q <= (idx_q <= IDX_W'(1));
                busy_q  <= (idx_q != '0);
            end
            if (cfg_ok) begin
                pat_q <= cfg_pat;
                len_q <= len_cl;
            end
            cnt_q <= cnt_d;
            irq_q <= irq_d;
        end
    end

    sd_shift_matcher #(.PAT_W(PAT_W), .LEN_W(3)) u_match (
        .clk     (clk),
        .reset   (reset),
        .shift_i (state_q == ST_SHIFT),
        .bit_i   (shreg_q[idx_q]),
        .clr_i   (flush | cfg_ok),
        .pat_i   (pat_q),
        .len_i   (len_q),
        .match_o (match)
    );

    assign in_ready  = ready_q;
    assign busy      = busy_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;
endmodule
